// File: rtl/avalon_master_port.sv
// Avalon-MM master: one CPU byte/half/word request -> one bus read/write. Latency: response 1 cycle after the last waitrequest-low edge.
// Backpressure: req_ready only in IDLE; waitrequest stalls BUS indefinitely (bounded by TIMEOUT_CYCLES when AVM_TIMEOUT_EN is defined).
module avalon_master_port #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wd_q, wd_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic        misaligned;
    logic [3:0]  be_new;
    logic [31:0] wd_new;
    logic [31:0] rd_shift;
    logic [31:0] load_data;

`ifdef AVM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    assign misaligned = (req_size == 2'b11)
                     || (req_size == 2'b01 && req_addr[0])
                     || (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    always_comb begin
        be_new = 4'b1111;
        wd_new = req_wdata;
        case (req_size)
            2'b00: begin
                be_new = 4'b0001 << req_addr[1:0];
                wd_new = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_new = req_addr[1] ? 4'b1100 : 4'b0011;
                wd_new = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Half loads are always lane 0 or 2, so one byte-granular shift serves both sizes.
    assign rd_shift = avm_readdata >> {lane_q, 3'b000};

    always_comb begin
        case (size_q)
            2'b00:   load_data = {{24{signed_q & rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_data = {{16{signed_q & rd_shift[15]}}, rd_shift[15:0]};
            default: load_data = avm_readdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wd_d     = wd_q;
        write_d  = write_q;
        size_d   = size_q;
        signed_d = signed_q;
        lane_d   = lane_q;
        rdata_d  = rdata_q;
        error_d  = error_q;
`ifdef AVM_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = {req_addr[31:2], 2'b00};
                    be_d     = be_new;
                    wd_d     = wd_new;
                    write_d  = req_write;
                    size_d   = req_size;
                    signed_d = req_signed;
                    lane_d   = req_addr[1:0];
                    rdata_d  = 32'h0;
                    error_d  = misaligned;
                    state_d  = misaligned ? RESP : BUS;
`ifdef AVM_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            BUS: begin
                if (!avm_waitrequest) begin
                    if (!write_q) rdata_d = load_data;
                    state_d = RESP;
                end
`ifdef AVM_TIMEOUT_EN
                // Completion above takes priority over a stall on the limit edge.
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    error_d = 1'b1;
                    rdata_d = 32'h0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= 32'h0;
            be_q     <= 4'h0;
            wd_q     <= 32'h0;
            write_q  <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            lane_q   <= 2'b00;
            rdata_q  <= 32'h0;
            error_q  <= 1'b0;
`ifdef AVM_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wd_q     <= wd_d;
            write_q  <= write_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            lane_q   <= lane_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
`ifdef AVM_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign avm_read       = (state_q == BUS) && !write_q;
    assign avm_write      = (state_q == BUS) && write_q;
    assign avm_address    = addr_q;
    assign avm_byteenable = be_q;
    assign avm_writedata  = wd_q;
    assign resp_valid     = (state_q == RESP);
    assign resp_rdata     = (state_q == RESP) ? rdata_q : 32'h0;
    assign resp_error     = (state_q == RESP) && error_q;

endmodule

// File: tb/tb_avalon_master_port.sv
// Directed bench for avalon_master_port; timeout steps compile in when AVM_TIMEOUT_EN is defined.
module tb_avalon_master_port;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    int total = 0;
    int bad   = 0;

    avalon_master_port #(.TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_write      (avm_write),
        .avm_byteenable (avm_byteenable),
        .avm_writedata  (avm_writedata),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata   (avm_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request, lets it be accepted on the next edge, then withdraws it.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = d;
        step();
        req_valid  = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        req_valid       = 1'b0;
        req_write       = 1'b0;
        req_size        = 2'b00;
        req_signed      = 1'b0;
        req_addr        = 32'h0;
        req_wdata       = 32'h0;
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'h0;
        #2;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_read",  {31'h0, avm_read}, 32'h0);
        chk("rst_write", {31'h0, avm_write}, 32'h0);
        chk("rst_resp",  {31'h0, resp_valid}, 32'h0);
        chk("rst_be",    {28'h0, avm_byteenable}, 32'h0);
        chk("rst_addr",  avm_address, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Word load, zero wait states
        avm_readdata = 32'h12345678;
        issue(1'b0, 2'b10, 1'b0, 32'hBFC00004, 32'h0);
        chk("wl_read",   {31'h0, avm_read}, 32'h1);
        chk("wl_write",  {31'h0, avm_write}, 32'h0);
        chk("wl_addr",   avm_address, 32'hBFC00004);
        chk("wl_be",     {28'h0, avm_byteenable}, 32'hF);
        chk("wl_ready",  {31'h0, req_ready}, 32'h0);
        chk("wl_noresp", {31'h0, resp_valid}, 32'h0);
        step();
        chk("wl_resp",   {31'h0, resp_valid}, 32'h1);
        chk("wl_rdata",  resp_rdata, 32'h12345678);
        chk("wl_err",    {31'h0, resp_error}, 32'h0);
        chk("wl_rdrop",  {31'h0, avm_read}, 32'h0);
        step();
        chk("wl_done",   {31'h0, resp_valid}, 32'h0);
        chk("wl_idle",   {31'h0, req_ready}, 32'h1);

        // Signed byte load, lane 3, three wait states
        avm_readdata = 32'h80FFFFFF;
        issue(1'b0, 2'b00, 1'b1, 32'hBFC00003, 32'h0);
        avm_waitrequest = 1'b1;
        chk("sb_be",     {28'h0, avm_byteenable}, 32'h8);
        chk("sb_addr",   avm_address, 32'hBFC00000);
        step(); step(); step();
        chk("sb_stall",  {31'h0, resp_valid}, 32'h0);
        chk("sb_held",   {31'h0, avm_read}, 32'h1);
        avm_waitrequest = 1'b0;
        step();
        chk("sb_resp",   {31'h0, resp_valid}, 32'h1);
        chk("sb_rdata",  resp_rdata, 32'hFFFFFF80);
        step();

        // Unsigned repeat
        issue(1'b0, 2'b00, 1'b0, 32'hBFC00003, 32'h0);
        step();
        chk("ub_rdata",  resp_rdata, 32'h00000080);
        step();

        // Signed half load from upper lanes
        avm_readdata = 32'h8001ABCD;
        issue(1'b0, 2'b01, 1'b1, 32'h00000102, 32'h0);
        chk("sh_be",     {28'h0, avm_byteenable}, 32'hC);
        step();
        chk("sh_rdata",  resp_rdata, 32'hFFFF8001);
        step();

        // Unsigned half load, lower lanes
        issue(1'b0, 2'b01, 1'b0, 32'h00000100, 32'h0);
        chk("uh_be",     {28'h0, avm_byteenable}, 32'h3);
        step();
        chk("uh_rdata",  resp_rdata, 32'h0000ABCD);
        step();

        // Half store with four wait states
        issue(1'b1, 2'b01, 1'b0, 32'hBFC00006, 32'h0000BEEF);
        avm_waitrequest = 1'b1;
        chk("hs_write",  {31'h0, avm_write}, 32'h1);
        chk("hs_read",   {31'h0, avm_read}, 32'h0);
        chk("hs_be",     {28'h0, avm_byteenable}, 32'hC);
        chk("hs_wd",     avm_writedata, 32'hBEEFBEEF);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hs_hold_w",  {31'h0, avm_write}, 32'h1);
            chk("hs_hold_wd", avm_writedata, 32'hBEEFBEEF);
            chk("hs_hold_a",  avm_address, 32'hBFC00004);
        end
        avm_waitrequest = 1'b0;
        step();
        chk("hs_resp",   {31'h0, resp_valid}, 32'h1);
        chk("hs_rdata",  resp_rdata, 32'h0);
        chk("hs_err",    {31'h0, resp_error}, 32'h0);
        step();

        // Byte store, lane 1
        issue(1'b1, 2'b00, 1'b0, 32'h00000201, 32'h123456A5);
        chk("bs_be",     {28'h0, avm_byteenable}, 32'h2);
        chk("bs_wd",     avm_writedata, 32'hA5A5A5A5);
        step(); step();

        // Misaligned word load
        issue(1'b0, 2'b10, 1'b0, 32'hBFC00002, 32'h0);
        chk("ma_read",   {31'h0, avm_read}, 32'h0);
        chk("ma_resp",   {31'h0, resp_valid}, 32'h1);
        chk("ma_err",    {31'h0, resp_error}, 32'h1);
        chk("ma_rdata",  resp_rdata, 32'h0);
        step();
        chk("ma_done",   {31'h0, resp_valid}, 32'h0);
        chk("ma_read2",  {31'h0, avm_read}, 32'h0);

        // Misaligned half and illegal size
        issue(1'b1, 2'b01, 1'b0, 32'h00000001, 32'h0);
        chk("mh_write",  {31'h0, avm_write}, 32'h0);
        chk("mh_err",    {31'h0, resp_error}, 32'h1);
        step();
        issue(1'b0, 2'b11, 1'b0, 32'h00000000, 32'h0);
        chk("ms_err",    {31'h0, resp_error}, 32'h1);
        step();

        // Reset while a write is stalled
        issue(1'b1, 2'b10, 1'b0, 32'h00000010, 32'hDEADBEEF);
        avm_waitrequest = 1'b1;
        chk("rs_write",  {31'h0, avm_write}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("rs_wdrop",  {31'h0, avm_write}, 32'h0);
        chk("rs_ready",  {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rs_noresp", {31'h0, resp_valid}, 32'h0);
            chk("rs_nowr",   {31'h0, avm_write}, 32'h0);
        end

`ifdef AVM_TIMEOUT_EN
        // Stuck waitrequest: abort on the eighth stall edge
        avm_readdata = 32'hCAFEF00D;
        issue(1'b0, 2'b10, 1'b0, 32'h00000100, 32'h0);
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 7; i++) step();
        chk("to_held",   {31'h0, avm_read}, 32'h1);
        step();
        chk("to_drop",   {31'h0, avm_read}, 32'h0);
        chk("to_resp",   {31'h0, resp_valid}, 32'h1);
        chk("to_err",    {31'h0, resp_error}, 32'h1);
        chk("to_rdata",  resp_rdata, 32'h0);
        avm_waitrequest = 1'b0;
        step();

        // Waitrequest falls on the limit cycle: completion wins
        issue(1'b0, 2'b10, 1'b0, 32'h00000100, 32'h0);
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 7; i++) step();
        avm_waitrequest = 1'b0;
        step();
        chk("tw_resp",   {31'h0, resp_valid}, 32'h1);
        chk("tw_err",    {31'h0, resp_error}, 32'h0);
        chk("tw_rdata",  resp_rdata, 32'hCAFEF00D);
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
